// File: rtl/fxp_to_fp_conv_if.sv
// rtl/fxp_to_fp_conv_if.sv - sample stream bundle for the fixed-to-float converter
//
// Ports (via modports):
//   valid_in  : upstream sample strobe
//   data_in   : IN_W-bit two's complement fixed-point sample
//   valid_out : converted sample strobe
//   data_out  : IEEE-754 single-precision result
// master drives the input side and observes results; slave is the converter.

interface fxp_to_fp_conv_if #(
  parameter int IN_W = 24
);
  logic            valid_in;
  logic [IN_W-1:0] data_in;
  logic            valid_out;
  logic [31:0]     data_out;

  modport master (output valid_in, output data_in, input valid_out, input data_out);
  modport slave  (input valid_in, input data_in, output valid_out, output data_out);
endinterface

// File: rtl/fxp_to_fp_conv.sv
// rtl/fxp_to_fp_conv.sv - 3-stage signed fixed-point to IEEE-754 single converter
//
// Ports:
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   s          : fxp_to_fp_conv_if.slave (valid_in/data_in in, valid_out/data_out out)
//   sample_cnt : 16-bit count of valid outputs, wraps (only with FXP2FP_CNT_EN)
// Optional feature macro: FXP2FP_CNT_EN.
// Stage 1: sign / magnitude / zero. Stage 2: leading-one search and
// left-normalise. Stage 3: round-to-nearest-even and pack.

module fxp_to_fp_conv #(
  parameter int IN_W   = 24,
  parameter int FRAC_W = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  fxp_to_fp_conv_if.slave   s
`ifdef FXP2FP_CNT_EN
  ,
  output logic [15:0]       sample_cnt
`endif
);

  localparam logic [IN_W-1:0] ONE     = {{(IN_W-1){1'b0}}, 1'b1};
  // Exponent bias folded with the fixed-point scale; always positive in range.
  localparam logic [8:0]      EXP_OFF = 9'(127 - FRAC_W);

  // ---------------- stage 1 ----------------
  logic            v1;
  logic            s1_sign;
  logic            s1_zero;
  logic [IN_W-1:0] s1_mag;

  // The IN_W-bit unsigned magnitude holds 2^(IN_W-1) exactly for the most
  // negative input, so no extra bit is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1      <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b1;
      s1_mag  <= '0;
    end else begin
      v1 <= s.valid_in;
      if (s.valid_in) begin
        s1_sign <= s.data_in[IN_W-1];
        s1_mag  <= s.data_in[IN_W-1] ? (~s.data_in + ONE) : s.data_in;
        s1_zero <= (s.data_in == '0);
      end
    end
  end

  // ---------------- stage 2 ----------------
  logic [4:0]  lead_pos;
  logic [31:0] mag_ext;
  logic [30:0] norm_low;

  always_comb begin
    lead_pos = '0;
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag[i]) lead_pos = 5'(i);
    end
  end

  assign mag_ext  = 32'(s1_mag);
  // The leading one lands on bit 31 and is implicit, so only bits 30:0 are kept.
  assign norm_low = 31'(mag_ext << (5'd31 - lead_pos));

  logic        v2;
  logic        s2_sign;
  logic        s2_zero;
  logic [4:0]  s2_pos;
  logic [30:0] s2_norm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2      <= 1'b0;
      s2_sign <= 1'b0;
      s2_zero <= 1'b1;
      s2_pos  <= '0;
      s2_norm <= '0;
    end else begin
      v2 <= v1;
      if (v1) begin
        s2_sign <= s1_sign;
        s2_zero <= s1_zero;
        s2_pos  <= lead_pos;
        s2_norm <= norm_low;
      end
    end
  end

  // ---------------- stage 3 ----------------
  logic [22:0] mant_raw;
  logic        guard_bit;
  logic        round_bit;
  logic        sticky_bit;
  logic        round_up;
  logic [23:0] mant_sum;
  logic        carry;
  logic [7:0]  exp_field;
  logic [31:0] result;

  assign mant_raw   = s2_norm[30:8];
  assign guard_bit  = s2_norm[7];
  assign round_bit  = s2_norm[6];
  assign sticky_bit = |s2_norm[5:0];
  // When p <= 23 the bits below the mantissa are all zero, so this never
  // rounds and the conversion is exact.
  assign round_up   = guard_bit & (round_bit | sticky_bit | mant_raw[0]);
  assign mant_sum   = {1'b0, mant_raw} + {23'd0, round_up};
  // On carry-out mant_sum[22:0] is already zero.
  assign carry      = mant_sum[23];
  assign exp_field  = 8'(9'(s2_pos) + EXP_OFF + {8'd0, carry});
  assign result     = s2_zero ? 32'h0000_0000 : {s2_sign, exp_field, mant_sum[22:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s.valid_out <= 1'b0;
      s.data_out  <= 32'h0000_0000;
    end else begin
      s.valid_out <= v2;
      if (v2) s.data_out <= result;
    end
  end

`ifdef FXP2FP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sample_cnt <= 16'd0;
    else if (s.valid_out) sample_cnt <= sample_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fxp_to_fp_conv.sv
// tb/tb_fxp_to_fp_conv.sv - directed table-driven bench for fxp_to_fp_conv

module tb_fxp_to_fp_conv;

  logic clk;
  logic rst_n;

  int n_cmp  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fxp_to_fp_conv_if #(.IN_W(24)) if_a ();
  fxp_to_fp_conv_if #(.IN_W(32)) if_b ();
  fxp_to_fp_conv_if #(.IN_W(32)) if_c ();

`ifdef FXP2FP_CNT_EN
  logic [15:0] cnt_a, cnt_b, cnt_c;
`endif

  fxp_to_fp_conv #(.IN_W(24), .FRAC_W(23)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(if_a)
`ifdef FXP2FP_CNT_EN
    , .sample_cnt(cnt_a)
`endif
  );
  fxp_to_fp_conv #(.IN_W(32), .FRAC_W(31)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(if_b)
`ifdef FXP2FP_CNT_EN
    , .sample_cnt(cnt_b)
`endif
  );
  fxp_to_fp_conv #(.IN_W(32), .FRAC_W(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .s(if_c)
`ifdef FXP2FP_CNT_EN
    , .sample_cnt(cnt_c)
`endif
  );

  typedef struct {
    int          dut;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t        tab[$];
  logic [31:0] last_a;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic [31:0] data);
    case (d)
      0: begin if_a.valid_in = v; if_a.data_in = data[23:0]; end
      1: begin if_b.valid_in = v; if_b.data_in = data; end
      default: begin if_c.valid_in = v; if_c.data_in = data; end
    endcase
  endtask

  task automatic sample(input int d, output logic vo, output logic [31:0] dv);
    case (d)
      0: begin vo = if_a.valid_out; dv = if_a.data_out; end
      1: begin vo = if_b.valid_out; dv = if_b.data_out; end
      default: begin vo = if_c.valid_out; dv = if_c.data_out; end
    endcase
  endtask

  // Back-to-back table run on one instance; output i is checked 3 edges after drive.
  task automatic run_table(input int d);
    vec_t        q[$];
    logic        vo;
    logic [31:0] dv;
    foreach (tab[k]) if (tab[k].dut == d) q.push_back(tab[k]);
    for (int i = 0; i < q.size() + 3; i++) begin
      @(posedge clk); #1;
      if (i >= 3) begin
        sample(d, vo, dv);
        check1($sformatf("tab%0d_valid_%0d", d, i - 3), vo, 1'b1);
        check32($sformatf("tab%0d_data_%0h", d, q[i-3].din), dv, q[i-3].dout);
        if (d == 0) last_a = q[i-3].dout;
      end
      if (i < q.size()) drive(d, 1'b1, q[i].din);
      else drive(d, 1'b0, 32'h0);
    end
    @(posedge clk); #1;
    sample(d, vo, dv);
    check1($sformatf("tab%0d_idle_valid", d), vo, 1'b0);
  endtask

  initial begin
    logic        pv[10];
    logic [31:0] pin[10];
    logic [31:0] pexp[10];
    logic        vo;
    logic [31:0] dv;

    // dut 0: IN_W=24 FRAC_W=23
    tab.push_back('{0, 32'h400000, 32'h3F000000});
    tab.push_back('{0, 32'hC00000, 32'hBF000000});
    tab.push_back('{0, 32'h000000, 32'h00000000});
    tab.push_back('{0, 32'h000001, 32'h34000000});
    tab.push_back('{0, 32'h800000, 32'hBF800000});
    tab.push_back('{0, 32'h7FFFFF, 32'h3F7FFFFE});
    tab.push_back('{0, 32'hFFFFFF, 32'hB4000000});
    tab.push_back('{0, 32'h200000, 32'h3E800000});
    tab.push_back('{0, 32'h000000, 32'h00000000});
    tab.push_back('{0, 32'hE00000, 32'hBE800000});
    // dut 1: IN_W=32 FRAC_W=31
    tab.push_back('{1, 32'h7FFFFFFF, 32'h3F800000});
    tab.push_back('{1, 32'h80000000, 32'hBF800000});
    tab.push_back('{1, 32'h40000000, 32'h3F000000});
    tab.push_back('{1, 32'h00000001, 32'h30000000});
    // dut 2: IN_W=32 FRAC_W=0
    tab.push_back('{2, 32'h01000001, 32'h4B800000});
    tab.push_back('{2, 32'h01000003, 32'h4B800002});
    tab.push_back('{2, 32'h01000002, 32'h4B800001});
    tab.push_back('{2, 32'h01000005, 32'h4B800002});
    tab.push_back('{2, 32'h01000007, 32'h4B800004});
    tab.push_back('{2, 32'h02000001, 32'h4C000000});
    tab.push_back('{2, 32'h02000003, 32'h4C000001});
    tab.push_back('{2, 32'h00000001, 32'h3F800000});
    tab.push_back('{2, 32'hFFFFFFFF, 32'hBF800000});
    tab.push_back('{2, 32'h80000000, 32'hCF000000});
    tab.push_back('{2, 32'h7FFFFFFF, 32'h4F000000});
    tab.push_back('{2, 32'h00000000, 32'h00000000});

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) drive(d, 1'b0, 32'h0);
    #3;
    for (int d = 0; d < 3; d++) begin
      sample(d, vo, dv);
      check1($sformatf("reset_valid_%0d", d), vo, 1'b0);
      check32($sformatf("reset_data_%0d", d), dv, 32'h0);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_table(0);
    run_table(1);
    run_table(2);

    // Stream with bubbles on cycles 3 and 7.
    for (int c = 0; c < 10; c++) begin
      pv[c]   = (c != 3) && (c != 7);
      pin[c]  = tab[c].din;
      pexp[c] = tab[c].dout;
    end
    for (int c = 0; c < 13; c++) begin
      @(posedge clk); #1;
      if (c >= 3) begin
        sample(0, vo, dv);
        check1($sformatf("bubble_valid_%0d", c - 3), vo, pv[c-3]);
        if (pv[c-3]) last_a = pexp[c-3];
        check32($sformatf("bubble_data_%0d", c - 3), dv, last_a);
      end
      if (c < 10) drive(0, pv[c], pin[c]);
      else drive(0, 1'b0, 32'h0);
    end

    // Reset with two samples in flight.
    @(posedge clk); #1; drive(0, 1'b1, 32'h400000);
    @(posedge clk); #1; drive(0, 1'b1, 32'hC00000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    drive(0, 1'b1, 32'h200000);
    #1;
    sample(0, vo, dv);
    check1("midrst_async_valid", vo, 1'b0);
    check32("midrst_async_data", dv, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(0, 1'b1, 32'hFFFFFF);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h0);
      sample(0, vo, dv);
      check1($sformatf("postrst_valid_%0d", k), vo, (k == 3));
      check32($sformatf("postrst_data_%0d", k), dv, (k >= 3) ? 32'hB4000000 : 32'h0);
    end

`ifdef FXP2FP_CNT_EN
    begin
      logic [15:0] before;
      before = cnt_a;
      for (int i = 0; i < 65537; i++) begin
        @(posedge clk); #1;
        drive(0, 1'b1, 32'h000001);
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 32'h0);
      repeat (4) @(posedge clk);
      #1;
      check32("sample_cnt_wrap", {16'h0, cnt_a}, {16'h0, 16'(before + 16'd1)});
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
